// File: rtl/matrix_stream_port_pkg.sv
// rtl/matrix_stream_port_pkg.sv - shared sizes, types and element indexing for matrix_stream_port
`ifndef WIDTH_BIT
`define WIDTH_BIT 1
`endif
`ifndef INDEX_BIT
`define INDEX_BIT 2
`endif

package matrix_stream_port_pkg;
  localparam int WIDTH_BIT = `WIDTH_BIT;
  localparam int INDEX_BIT = `INDEX_BIT;
  localparam int WIDTH     = 1 << WIDTH_BIT;
  localparam int N_ELEM    = WIDTH * WIDTH;
  localparam int CNT_W     = 2 * WIDTH_BIT + 1;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef logic [0:WIDTH-1][0:WIDTH-1][31:0] matrix_t;
  typedef logic [CNT_W-1:0]                  count_t;
  typedef logic [INDEX_BIT-1:0]              index_t;

  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, SNAP, DUMP} state_t;

  typedef struct packed {
    logic [WIDTH_BIT-1:0] row;
    logic [WIDTH_BIT-1:0] col;
  } elem_pos_t;

  // Row-major: element 0 is [0][0], the most significant word of matrix_t.
  function automatic elem_pos_t elem_pos(input count_t k);
    elem_pos_t p;
    p.row = WIDTH_BIT'(k >> WIDTH_BIT);
    p.col = WIDTH_BIT'(k);
    return p;
  endfunction
endpackage

// File: rtl/matrix_stream_port_if.sv
// rtl/matrix_stream_port_if.sv - command, element stream and memory port bundle
interface matrix_stream_port_if;
  import matrix_stream_port_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  logic    cmd_op;
  index_t  cmd_index;
  logic    in_valid;
  logic    in_ready;
  logic [31:0] in_data;
  logic    out_valid;
  logic    out_ready;
  logic [31:0] out_data;
  logic    out_last;
  logic    mem_write_enable;
  index_t  mem_write;
  matrix_t mem_write_data;
  index_t  mem_read;
  matrix_t mem_read_data;
  logic    busy;
  logic    done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, in_valid, in_data, out_ready, mem_read_data,
    output cmd_ready, in_ready, out_valid, out_data, out_last,
           mem_write_enable, mem_write, mem_write_data, mem_read, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_index, in_valid, in_data, out_ready, mem_read_data,
    input  cmd_ready, in_ready, out_valid, out_data, out_last,
           mem_write_enable, mem_write, mem_write_data, mem_read, busy, done
  );
endinterface

// File: rtl/matrix_stream_port_buffer.sv
// rtl/matrix_stream_port_buffer.sv - matrix register with element and whole-matrix access
module matrix_element_buffer
  import matrix_stream_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  elem_pos_t   wr_pos,
  input  logic [31:0] wr_data,
  input  logic        load_en,
  input  matrix_t     load_data,
  input  elem_pos_t   rd_pos,
  output logic [31:0] rd_data,
  output matrix_t     all_data
);
  matrix_t mat;

  always_ff @(posedge clk) begin
    if (rst) begin
      mat <= '0;
    end else if (load_en) begin
      mat <= load_data;
    end else if (wr_en) begin
      mat[wr_pos.row][wr_pos.col] <= wr_data;
    end
  end

  assign rd_data  = mat[rd_pos.row][rd_pos.col];
  assign all_data = mat;
endmodule

// File: rtl/matrix_stream_port.sv
// rtl/matrix_stream_port.sv - serial load/dump front end for data_memory matrix slots
module matrix_stream_port
  import matrix_stream_port_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  matrix_stream_port_if.slave bus
);
  state_t state;
  state_t state_next;
  count_t count;
  logic   done_next;

  logic cmd_fire;
  logic in_fire;
  logic out_fire;
  logic at_last;

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign at_last  = (count == count_t'(N_ELEM - 1));

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:   if (cmd_fire) state_next = (bus.cmd_op == OP_LOAD) ? LOAD : SNAP;
      LOAD:   if (in_fire && at_last) state_next = COMMIT;
      COMMIT: state_next = IDLE;
      SNAP:   state_next = DUMP;
      DUMP: begin
        if (out_fire && at_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == COMMIT) done_next = 1'b1;
  end

  // Handshake and strobe outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state                <= IDLE;
      count                <= '0;
      bus.mem_write        <= '0;
      bus.mem_read         <= '0;
      bus.cmd_ready        <= 1'b0;
      bus.in_ready         <= 1'b0;
      bus.out_valid        <= 1'b0;
      bus.mem_write_enable <= 1'b0;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
    end else begin
      state                <= state_next;
      bus.cmd_ready        <= (state_next == IDLE);
      bus.in_ready         <= (state_next == LOAD);
      bus.out_valid        <= (state_next == DUMP);
      bus.mem_write_enable <= (state_next == COMMIT);
      bus.busy             <= (state_next != IDLE);
      bus.done             <= done_next;
      if (cmd_fire) begin
        count <= '0;
        if (bus.cmd_op == OP_LOAD) bus.mem_write <= bus.cmd_index;
        else                       bus.mem_read  <= bus.cmd_index;
      end else if (state == SNAP) begin
        count <= '0;
      end else if (in_fire || out_fire) begin
        count <= count + count_t'(1);
      end
    end
  end

  logic [31:0] rd_data;
  matrix_t     all_data;

  matrix_element_buffer u_buffer (
    .clk       (CLK),
    .rst       (RST),
    .wr_en     (in_fire),
    .wr_pos    (elem_pos(count)),
    .wr_data   (bus.in_data),
    .load_en   (state == SNAP),
    .load_data (bus.mem_read_data),
    .rd_pos    (elem_pos(count)),
    .rd_data   (rd_data),
    .all_data  (all_data)
  );

  assign bus.out_data       = rd_data;
  assign bus.out_last       = bus.out_valid && at_last;
  assign bus.mem_write_data = all_data;
endmodule

// File: tb/tb_matrix_stream_port.sv
// tb/tb_matrix_stream_port.sv - scoreboard bench for matrix_stream_port
module tb_matrix_stream_port;
  import matrix_stream_port_pkg::*;

  typedef struct packed {
    index_t  idx;
    matrix_t data;
  } wr_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } out_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_stream_port_if bus ();

  matrix_stream_port dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  matrix_t tbmem [4];
  logic    ext_we = 1'b0;
  index_t  ext_idx = '0;
  matrix_t ext_data = '0;

  assign bus.mem_read_data = tbmem[bus.mem_read];

  always @(posedge clk) begin
    if (bus.mem_write_enable) tbmem[bus.mem_write] <= bus.mem_write_data;
    if (ext_we) tbmem[ext_idx] <= ext_data;
  end

  int checks = 0;
  int failures = 0;
  wr_exp_t  exp_wr[$];
  out_exp_t exp_out[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic matrix_t mk(input logic [31:0] a, b, c, d);
    matrix_t m;
    m[0][0] = a; m[0][1] = b; m[1][0] = c; m[1][1] = d;
    return m;
  endfunction

  // Scoreboard monitors: sample at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_write_enable) begin
      if (exp_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write slot=%0d", bus.mem_write);
      end else begin
        wr_exp_t e;
        e = exp_wr.pop_front();
        chk("write_slot", 128'(bus.mem_write), 128'(e.idx));
        chk("write_data", bus.mem_write_data, e.data);
        chk("write_done", 128'(bus.done), 128'(1'b1));
      end
    end
    if (bus.out_valid) begin
      if (exp_out.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out data=%h", bus.out_data);
      end else begin
        chk("out_data", 128'(bus.out_data), 128'(exp_out[0].data));
        chk("out_last", 128'(bus.out_last), 128'(exp_out[0].last));
        if (bus.out_ready) void'(exp_out.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_out(input logic [31:0] a, b, c, d);
    out_exp_t e;
    e.last = 1'b0;
    e.data = a; exp_out.push_back(e);
    e.data = b; exp_out.push_back(e);
    e.data = c; exp_out.push_back(e);
    e.data = d; e.last = 1'b1; exp_out.push_back(e);
  endtask

  task automatic push_wr(input index_t idx, input matrix_t m);
    wr_exp_t e;
    e.idx = idx; e.data = m;
    exp_wr.push_back(e);
  endtask

  task automatic ext_write(input index_t idx, input matrix_t m);
    ext_we = 1'b1; ext_idx = idx; ext_data = m;
    tick();
    ext_we = 1'b0;
  endtask

  task automatic do_cmd(input logic op, input index_t idx);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_index = idx;
    while (!bus.cmd_ready && n < 20) begin tick(); n++; end
    if (!bus.cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout cmd_ready=%b required=1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load_b2b(input index_t idx, input logic [31:0] a, b, c, d);
    logic [31:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    push_wr(idx, mk(a, b, c, d));
    do_cmd(OP_LOAD, idx);
    chk("load_in_ready", 128'(bus.in_ready), 128'(1'b1));
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = v[i];
      tick();
    end
    bus.in_valid = 1'b0;
    chk("commit_we", 128'(bus.mem_write_enable), 128'(1'b1));
    chk("commit_done", 128'(bus.done), 128'(1'b1));
    tick();
    chk("commit_one_cycle", 128'(bus.mem_write_enable), 128'(1'b0));
    chk("commit_idle_ready", 128'(bus.cmd_ready), 128'(1'b1));
  endtask

  task automatic wait_dump_done(input string name);
    int n = 0;
    while (!bus.done && n < 16) begin tick(); n++; end
    chk(name, 128'(bus.done), 128'(1'b1));
    chk({name, "_idle"}, 128'(bus.cmd_ready), 128'(1'b1));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bit in_pat [7];
    bit rd_pat [6];
    logic [31:0] nv;
    in_pat = '{1, 0, 0, 1, 1, 0, 1};
    rd_pat = '{1, 0, 1, 1, 0, 1};

    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_index = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    tick(); tick();
    chk("reset_cmd_ready", 128'(bus.cmd_ready), 128'(1'b0));
    chk("reset_busy", 128'(bus.busy), 128'(1'b0));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("reset_write_data", bus.mem_write_data, 128'(0));
    rst = 1'b0;
    tick();
    chk("post_reset_cmd_ready", 128'(bus.cmd_ready), 128'(1'b1));

    // back-to-back load
    load_b2b(2'd2, 32'h11, 32'h22, 32'h33, 32'h44);

    // stalled load
    push_wr(2'd1, mk(32'hA1, 32'hA2, 32'hA3, 32'hA4));
    do_cmd(OP_LOAD, 2'd1);
    nv = 32'hA1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = in_pat[i];
      bus.in_data  = in_pat[i] ? nv : 32'hDEAD_BEEF;
      if (in_pat[i]) nv = nv + 32'd1;
      tick();
      if (i == 5) chk("stall_no_early_write", 128'(bus.mem_write_enable), 128'(1'b0));
    end
    bus.in_valid = 1'b0;
    chk("stall_commit_we", 128'(bus.mem_write_enable), 128'(1'b1));
    tick();

    // dump with back-pressure
    ext_write(2'd3, mk(32'd5, 32'd6, 32'd7, 32'd8));
    push_out(32'd5, 32'd6, 32'd7, 32'd8);
    do_cmd(OP_DUMP, 2'd3);
    chk("snap_busy", 128'(bus.busy), 128'(1'b1));
    chk("snap_read_slot", 128'(bus.mem_read), 128'(2'd3));
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = rd_pat[i];
      tick();
      if (i < 5) chk("dump_no_early_done", 128'(bus.done), 128'(1'b0));
    end
    bus.out_ready = 1'b0;
    chk("dump_done", 128'(bus.done), 128'(1'b1));
    chk("dump_idle", 128'(bus.cmd_ready), 128'(1'b1));
    chk("dump_out_valid_low", 128'(bus.out_valid), 128'(1'b0));

    // snapshot isolation
    ext_write(2'd0, mk(32'd1, 32'd2, 32'd3, 32'd4));
    push_out(32'd1, 32'd2, 32'd3, 32'd4);
    do_cmd(OP_DUMP, 2'd0);
    tick();
    bus.out_ready = 1'b1;
    ext_write(2'd0, mk(32'hFF, 32'hFF, 32'hFF, 32'hFF));
    wait_dump_done("snap_done");

    // reset mid-load
    do_cmd(OP_LOAD, 2'd1);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h55; tick();
    bus.in_data = 32'h66; tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_we", 128'(bus.mem_write_enable), 128'(1'b0));
    chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1'b0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b0));
    chk("rst_busy", 128'(bus.busy), 128'(1'b0));
    chk("rst_done", 128'(bus.done), 128'(1'b0));
    chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
    chk("rst_buffer", bus.mem_write_data, 128'(0));
    rst = 1'b0;
    tick();
    chk("rst_release_ready", 128'(bus.cmd_ready), 128'(1'b1));
    load_b2b(2'd2, 32'h11, 32'h22, 32'h33, 32'h44);

    // command held during a busy load, then a dump of slot 2
    push_wr(2'd1, mk(32'h71, 32'h72, 32'h73, 32'h74));
    push_out(32'h11, 32'h22, 32'h33, 32'h44);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_LOAD; bus.cmd_index = 2'd1;
    tick();
    bus.cmd_op = OP_DUMP; bus.cmd_index = 2'd2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("busy_cmd_ready", 128'(bus.cmd_ready), 128'(1'b0));
      bus.in_data = 32'h71 + i;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("busy_commit_cmd_ready", 128'(bus.cmd_ready), 128'(1'b0));
    tick();
    chk("busy_after_commit_ready", 128'(bus.cmd_ready), 128'(1'b1));
    tick();
    bus.cmd_valid = 1'b0;
    chk("second_cmd_accepted", 128'(bus.busy), 128'(1'b1));
    chk("second_cmd_slot", 128'(bus.mem_read), 128'(2'd2));
    bus.out_ready = 1'b1;
    wait_dump_done("second_dump_done");

    tick(); tick();
    chk("write_queue_drained", 128'(exp_wr.size()), 128'(0));
    chk("out_queue_drained", 128'(exp_out.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout time=%0t limit=100000", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/matrix_stream_port.md
Name: matrix_stream_port

Overview:
- Serial front end to data_memory.
- Load direction: accepts a stream of 32-bit elements over valid/ready and assembles one WIDTH x WIDTH matrix.
- Load commit: writes the assembled matrix into a selected memory slot through the memory's write port.
- Dump direction: snapshots one slot via a memory read port and streams its elements out row-major.
- Used by the testbench host and the external loader in place of file-based memory initialisation.

Parameters:
- WIDTH, 2**`WIDTH_BIT, matrix dimension, must match data_memory.
- N_ELEM, WIDTH*WIDTH, derived localparam, elements per matrix.
- `WIDTH_BIT and `INDEX_BIT come from CONSTANT.v.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = load, 1 = dump.
- cmd_index  in  `INDEX_BIT  target memory slot.
- in_valid  in  1  load element offered.
- in_ready  out  1  high only in LOAD.
- in_data  in  32  load element.
- out_valid  out  1  dump element valid.
- out_ready  in  1  downstream accepts.
- out_data  out  32  dump element.
- out_last  out  1  marks element N_ELEM-1.
- mem_write_enable  out  1  to data_memory write_enable.
- mem_write  out  `INDEX_BIT  to data_memory write.
- mem_write_data  out  [0:WIDTH-1][0:WIDTH-1][31:0]  to data_memory write_data.
- mem_read  out  `INDEX_BIT  to a data_memory read port.
- mem_read_data  in  [0:WIDTH-1][0:WIDTH-1][31:0]  combinational data from that port.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Element counter, buffer, mem_write and mem_read are cleared to 0.
  - All handshake and strobe outputs are 0.
  - cmd_ready is 1 in the first cycle after reset is released.
- Handshake rule: a transfer occurs on a rising edge where valid && ready are both high.
- Element ordering:
  - Element k maps to row k>>`WIDTH_BIT, column k&(WIDTH-1), row-major.
  - Element 0 is [0][0], the MSB word of the packed matrix.
- States: IDLE, LOAD, COMMIT, SNAP, DUMP.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake: latch cmd_index into mem_write (load) or mem_read (dump) and clear the counter.
  - Next state is LOAD (op 0) or SNAP (op 1).
  - cmd_valid while not IDLE is ignored, because cmd_ready=0.
- LOAD:
  - in_ready=1.
  - Each handshake writes in_data into buffer[k] and increments k.
  - Back-pressure is unbounded: in_valid low simply holds state.
  - The handshake at k=N_ELEM-1 moves to COMMIT.
- COMMIT (exactly 1 cycle):
  - mem_write_enable=1, mem_write_data=buffer (including the last element), done=1.
  - Next state is IDLE.
  - Load latency: N_ELEM element handshakes plus 1 cycle.
- SNAP (1 cycle):
  - buffer <= mem_read_data (mem_read was stable since the IDLE edge).
  - Counter = 0, next state is DUMP.
- DUMP:
  - out_valid=1, out_data=buffer[k], out_last=(k==N_ELEM-1).
  - out_data and out_last are held stable while out_ready=0.
  - Each handshake increments k.
  - The handshake with out_last asserts done in the following cycle, which is also IDLE with cmd_ready=1.
- Snapshot semantics: memory writes to the dumped slot after SNAP do not affect the streamed data.
- mem_write_enable is never asserted outside COMMIT.
- Reset mid-LOAD: partial matrix discarded, no memory write.
- Reset mid-DUMP: stream truncated, out_last never sent.
- Counter width is `WIDTH_BIT*2+1 bits so it never wraps within a command. The counter is cleared on every command accept.
- WIDTH=1 (N_ELEM=1): LOAD lasts exactly one handshake, and DUMP's first element carries out_last.

Decomposition:
- Shared package (alongside CONSTANT.v):
  - N_ELEM.
  - State encoding enum {IDLE, LOAD, COMMIT, SNAP, DUMP}.
  - OP_LOAD = 1'b0, OP_DUMP = 1'b1.
  - Element-index-to-(row, col) helper function.
- One sub-module, matrix_element_buffer:
  - WIDTH x WIDTH x 32 register.
  - Indexed single-element write.
  - Whole-matrix parallel load (used by SNAP).
  - Indexed single-element read.
  - Whole-matrix parallel read (used by COMMIT).
- The FSM and counter stay in the top.

Test Plan (WIDTH_BIT=1, so WIDTH=2 and N_ELEM=4; INDEX_BIT=2):
- Back-to-back load:
  - Stimulus: load slot 2, elements 0x11,0x22,0x33,0x44 with in_valid held high.
  - Response: exactly one mem_write_enable cycle 1 cycle after the 4th handshake, mem_write=2, mem_write_data rows {0x11,0x22},{0x33,0x44}, done in the same cycle.
- Stalled load:
  - Stimulus: load slot 1, in_valid toggled 1-0-0-1-1-0-1.
  - Response: only 4 elements are captured, in order, and the write lands 1 cycle after the 4th accept.
- Dump with back-pressure:
  - Stimulus: preload slot 3 with {5,6},{7,8}; dump slot 3 with out_ready pattern 1,0,1,1,0,1.
  - Response: out_data sequence 5,6,7,8 with values held during stalls, out_last only with 8, done 1 cycle after the final handshake.
- Snapshot isolation:
  - Stimulus: dump slot 0 (contents {1,2},{3,4}); after SNAP, an external write sets slot 0 to all 0xFF.
  - Response: stream is still 1,2,3,4.
- Reset mid-load:
  - Stimulus: RST asserted after 2 load elements.
  - Response: no mem_write_enable, next cycle all outputs 0, cmd_ready=1 after RST drops, next load behaves as the first scenario.
- Command during busy:
  - Stimulus: cmd_valid held high during a load.
  - Response: cmd_ready=0 until the cycle after COMMIT, and the second command is accepted only then.
